// File: rtl/intersection_scheduler.sv
// -----------------------------------------------------------------------------
// intersection_scheduler
//   Four-phase traffic-light scheduler. Each served phase runs GREEN, then a
//   fixed YELLOW interval, then a fixed ALL_RED clearance, before the next
//   phase is chosen (preemption first, otherwise round-robin over requests).
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   req        : [3:0] level vehicle-waiting request, one bit per phase
//   preempt    : emergency preemption request (level)
//   preempt_ph : [1:0] phase demanded by preempt
//   grn        : [3:0] one-hot green for the current phase
//   yel        : [3:0] one-hot yellow for the current phase
//   all_red    : all phases red (IDLE or ALL_RED clearance)
//   cur_ph     : [1:0] current or last served phase
//   served     : one-cycle pulse in the cycle after GREEN exits
// -----------------------------------------------------------------------------
module intersection_scheduler #(
  parameter int unsigned MIN_GRN = 4,
  parameter int unsigned MAX_GRN = 10,
  parameter int unsigned YEL_CYC = 3,
  parameter int unsigned RED_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       preempt,
  input  logic [1:0] preempt_ph,
  output logic [3:0] grn,
  output logic [3:0] yel,
  output logic       all_red,
  output logic [1:0] cur_ph,
  output logic       served
);

  localparam int unsigned TW = 4;
  localparam int unsigned PW = 2;

  // Last timer value of each interval (timer reads 0 in a state's first cycle).
  localparam logic [TW-1:0] MIN_LAST = TW'(MIN_GRN - 1);
  localparam logic [TW-1:0] MAX_LAST = TW'(MAX_GRN - 1);
  localparam logic [TW-1:0] YEL_LAST = TW'(YEL_CYC - 1);
  localparam logic [TW-1:0] RED_LAST = TW'(RED_CYC - 1);
  localparam logic [TW-1:0] TMR_SAT  = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GREEN   = 2'd1,
    S_YELLOW  = 2'd2,
    S_ALL_RED = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [3:0]    grn_q, grn_d;
  logic [3:0]    yel_q, yel_d;
  logic          all_red_q, all_red_d;
  logic          served_q, served_d;

  logic [PW-1:0] cand;
  logic [PW-1:0] rr_ph;
  logic          rr_hit;
  logic [PW-1:0] sel_ph;
  logic          go;
  logic          other;

  function automatic logic [3:0] onehot(input logic [PW-1:0] p);
    onehot = 4'b0001 << p;
  endfunction

  // Round-robin search: ph_q+1, ph_q+2, ph_q+3, then ph_q itself last.
  always_comb begin
    cand   = ph_q;
    rr_ph  = ph_q;
    rr_hit = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = ph_q + PW'(k);
      if (!rr_hit && req[cand]) begin
        rr_hit = 1'b1;
        rr_ph  = cand;
      end
    end
  end

  assign sel_ph = preempt ? preempt_ph : rr_ph;
  assign go     = preempt | (|req);
  assign other  = |(req & ~onehot(ph_q));

  // Next-state, phase, timer and registered-output decode.
  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    timer_d   = timer_q;
    grn_d     = 4'b0000;
    yel_d     = 4'b0000;
    all_red_d = 1'b0;
    served_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_GREEN;
          ph_d    = sel_ph;
        end
      end
      S_GREEN: begin
        if (preempt) begin
          // Preemption ignores MIN_GRN but holds if it already owns the green.
          if (preempt_ph != ph_q) begin
            state_d = S_YELLOW;
          end
        end else if (other && ((!req[ph_q] && (timer_q >= MIN_LAST)) ||
                               (timer_q >= MAX_LAST))) begin
          state_d = S_YELLOW;
        end
      end
      S_YELLOW: begin
        if (timer_q >= YEL_LAST) begin
          state_d = S_ALL_RED;
        end
      end
      S_ALL_RED: begin
        if (timer_q >= RED_LAST) begin
          if (go) begin
            state_d = S_GREEN;
            ph_d    = sel_ph;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Timer restarts on any state change, otherwise counts up and saturates.
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q != TMR_SAT) begin
      timer_d = timer_q + TW'(1);
    end

    // Outputs are computed from the next state so that the registers hold
    // the decode of the current state.
    if (state_d == S_GREEN) begin
      grn_d = onehot(ph_d);
    end
    if (state_d == S_YELLOW) begin
      yel_d = onehot(ph_d);
    end
    all_red_d = (state_d == S_IDLE) || (state_d == S_ALL_RED);
    served_d  = (state_q == S_GREEN) && (state_d != S_GREEN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      ph_q      <= '0;
      grn_q     <= 4'b0000;
      yel_q     <= 4'b0000;
      all_red_q <= 1'b1;
      served_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      ph_q      <= ph_d;
      grn_q     <= grn_d;
      yel_q     <= yel_d;
      all_red_q <= all_red_d;
      served_q  <= served_d;
    end
  end

  assign grn     = grn_q;
  assign yel     = yel_q;
  assign all_red = all_red_q;
  assign cur_ph  = ph_q;
  assign served  = served_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// -----------------------------------------------------------------------------
// tb_intersection_scheduler
//   Scoreboard bench: each scenario pushes the per-cycle expected light
//   pattern {grn, yel, all_red, served, cur_ph} into a queue while it sets the
//   inputs; the queue is then drained one entry per clock and compared.
// -----------------------------------------------------------------------------
module tb_intersection_scheduler;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       preempt;
  logic [1:0] preempt_ph;
  logic [3:0] grn;
  logic [3:0] yel;
  logic       all_red;
  logic [1:0] cur_ph;
  logic       served;

  intersection_scheduler #(
    .MIN_GRN(4),
    .MAX_GRN(10),
    .YEL_CYC(3),
    .RED_CYC(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .preempt   (preempt),
    .preempt_ph(preempt_ph),
    .grn       (grn),
    .yel       (yel),
    .all_red   (all_red),
    .cur_ph    (cur_ph),
    .served    (served)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      tag;
    logic [11:0] v;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  localparam logic [11:0] RST_VEC = {4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0};

  function automatic logic [11:0] obs();
    obs = {grn, yel, all_red, served, cur_ph};
  endfunction

  task automatic check_val(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {grn,yel,ar,srv,ph}=%b_%b_%b_%b_%0d expected %b_%b_%b_%b_%0d",
               tag, got[11:8], got[7:4], got[3], got[2], got[1:0],
               exp[11:8], exp[7:4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  task automatic push(input int n, input string tag, input logic [3:0] g,
                      input logic [3:0] y, input logic ar, input logic sv,
                      input logic [1:0] ph);
    exp_t e;
    e.tag = tag;
    e.v   = {g, y, ar, sv, ph};
    repeat (n) sb_q.push_back(e);
  endtask

  // Expected yellow (served in its first cycle) plus clearance after a green.
  task automatic push_clear(input string tag, input logic [1:0] ph);
    logic [3:0] oh;
    oh = 4'b0001 << ph;
    push(1, {tag, "_yel0"}, 4'b0000, oh, 1'b0, 1'b1, ph);
    push(2, {tag, "_yel"},  4'b0000, oh, 1'b0, 1'b0, ph);
    push(2, {tag, "_red"},  4'b0000, 4'b0000, 1'b1, 1'b0, ph);
  endtask

  task automatic push_green(input int n, input string tag, input logic [1:0] ph);
    logic [3:0] oh;
    oh = 4'b0001 << ph;
    push(n, tag, oh, 4'b0000, 1'b0, 1'b0, ph);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      @(posedge clk);
      @(negedge clk);
      e = sb_q.pop_front();
      check_val(e.tag, obs(), e.v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req        = 4'b0000;
    preempt    = 1'b0;
    preempt_ph = 2'd0;
    rst_n      = 1'b0;
    #2;
    check_val("rst_async", obs(), RST_VEC);
    @(negedge clk);
    check_val("rst_hold", obs(), RST_VEC);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    req        = 4'b0000;
    preempt    = 1'b0;
    preempt_ph = 2'd0;

    // No requests: stays in IDLE with all red.
    do_reset();
    push(50, "idle", 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0);
    drain();

    // Single request on phase 0: green next cycle, rests, never served.
    do_reset();
    req = 4'b0001;
    push_green(50, "rest_ph0", 2'd0);
    drain();

    // Competing request while req[0] held: green limited to MAX_GRN.
    do_reset();
    req = 4'b0001;
    push_green(1, "max_g0", 2'd0);
    drain();
    req = 4'b0101;
    push_green(9, "max_g0", 2'd0);
    push_clear("max_c0", 2'd0);
    push_green(3, "max_g2", 2'd2);
    drain();

    // req[0] dropped with a competitor: green lasts exactly MIN_GRN.
    do_reset();
    req = 4'b0001;
    push_green(1, "min_g0", 2'd0);
    drain();
    req = 4'b0010;
    push_green(3, "min_g0", 2'd0);
    push_clear("min_c0", 2'd0);
    push_green(8, "min_g1", 2'd1);
    drain();

    // All phases requesting: round-robin 1,2,3,0,1 at MAX_GRN each.
    do_reset();
    req = 4'b1111;
    push_green(10, "rr_g1", 2'd1); push_clear("rr_c1", 2'd1);
    push_green(10, "rr_g2", 2'd2); push_clear("rr_c2", 2'd2);
    push_green(10, "rr_g3", 2'd3); push_clear("rr_c3", 2'd3);
    push_green(10, "rr_g0", 2'd0); push_clear("rr_c0", 2'd0);
    push_green(10, "rr_g1b", 2'd1);
    drain();

    // Preempt to phase 3 at green timer 1; holds while preempt is high.
    do_reset();
    req = 4'b0001;
    push_green(2, "pre_g0", 2'd0);
    drain();
    preempt    = 1'b1;
    preempt_ph = 2'd3;
    push_clear("pre_c0", 2'd0);
    push_green(20, "pre_g3", 2'd3);
    drain();
    preempt = 1'b0;
    push(1, "pre_rel", 4'b0000, 4'b1000, 1'b0, 1'b1, 2'd3);
    drain();

    // Asynchronous reset in the middle of YELLOW.
    do_reset();
    req = 4'b0001;
    push_green(1, "ar_g0", 2'd0);
    drain();
    req = 4'b0010;
    push_green(3, "ar_g0", 2'd0);
    push(1, "ar_yel0", 4'b0000, 4'b0001, 1'b0, 1'b1, 2'd0);
    push(1, "ar_yel1", 4'b0000, 4'b0001, 1'b0, 1'b0, 2'd0);
    drain();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("ar_async", obs(), RST_VEC);
    @(negedge clk);
    check_val("ar_hold", obs(), RST_VEC);
    // First selection after reset searches from phase 1.
    req   = 4'b0011;
    rst_n = 1'b1;
    push_green(1, "ar_first", 2'd1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/intersection_scheduler.md
INTERSECTION_SCHEDULER -- requirements
Module: intersection_scheduler

Interface
REQ-001 The block SHALL have parameter MIN_GRN, 4, minimum green cycles per phase.
REQ-002 The block SHALL have parameter MAX_GRN, 10, maximum green cycles while a competing request exists.
REQ-003 The block SHALL have parameter YEL_CYC, 3, yellow cycles.
REQ-004 The block SHALL have parameter RED_CYC, 2, all-red clearance cycles.
REQ-005 Parameter legality SHALL be 1 <= MIN_GRN <= MAX_GRN <= 15 and 1 <= YEL_CYC, RED_CYC <= 15.
REQ-006 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 The block SHALL have port req, input, 4, level vehicle-waiting request per phase 0..3.
REQ-009 The block SHALL have port preempt, input, 1, emergency preemption request (level).
REQ-010 The block SHALL have port preempt_ph, input, 2, phase demanded by preempt.
REQ-011 The block SHALL have port grn, output, 4, one-hot green for the current phase.
REQ-012 The block SHALL have port yel, output, 4, one-hot yellow for the current phase.
REQ-013 The block SHALL have port all_red, output, 1, all phases red.
REQ-014 The block SHALL have port cur_ph, output, 2, current or last served phase.
REQ-015 The block SHALL have port served, output, 1, one-cycle pulse on the cycle after GREEN exits.

Function
REQ-016 The FSM SHALL have states IDLE, GREEN, YELLOW, ALL_RED.
REQ-017 A 4-bit timer SHALL clear on every state change and increment otherwise, saturating at 15; it reads 0 in the first cycle of each state.
REQ-018 All outputs SHALL be decoded from registered state only, with no combinational input-to-output path.
REQ-019 Output decode per state SHALL be: GREEN grn=onehot(cur_ph); YELLOW yel=onehot(cur_ph); IDLE/ALL_RED all_red=1; unlisted outputs 0.
REQ-020 Phase selection SHALL be: preempt ? preempt_ph : round-robin over req starting at cur_ph+1 mod 4, with cur_ph searched last.
REQ-021 IDLE SHALL transition to GREEN with the selected phase when preempt or |req; a request sampled in cycle t gives green visible in t+1.
REQ-022 With no request present, GREEN SHALL rest (hold) indefinitely while no other phase requests and preempt is low.
REQ-023 With preempt low and other = |(req & ~onehot(cur_ph)), GREEN SHALL exit to YELLOW when other && ((!req[cur_ph] && timer >= MIN_GRN-1) || timer >= MAX_GRN-1).
REQ-024 With preempt high and preempt_ph != cur_ph, GREEN SHALL exit to YELLOW the next edge, ignoring MIN_GRN; with preempt_ph == cur_ph, GREEN SHALL hold.
REQ-025 YELLOW SHALL last exactly YEL_CYC cycles and ALL_RED exactly RED_CYC cycles; yellow and clearance SHALL never be shortened, including by preempt.
REQ-026 At the end of ALL_RED, the FSM SHALL enter GREEN with the selected phase (REQ-020) if preempt or |req, else IDLE.
REQ-027 cur_ph SHALL update only on entry to GREEN.
REQ-028 grn and yel SHALL never both be nonzero, and at most one bit of each SHALL be set.
REQ-029 Simultaneous requests SHALL be served in round-robin order, with no phase starved while its req is held.

Reset
REQ-030 On rst_n low, the block SHALL enter IDLE immediately, with timer=0, cur_ph=0, grn=0, yel=0, all_red=1, served=0, regardless of the current state.
REQ-031 After rst_n rises, the first selection SHALL search from phase 1.

Verification
REQ-032 The bench SHALL cover: reset, req=0, preempt=0 for 50 cycles -> all_red=1, grn=0 throughout.
REQ-033 The bench SHALL cover: req=0001 only -> grn=0001 from the next cycle and held for 50 cycles, served never pulses.
REQ-034 The bench SHALL cover: req[0] held with req[2] raised at green timer 0 -> grn=0001 for 10 cycles, yel=0001 for 3 cycles, all_red for 2 cycles, then grn=0100.
REQ-035 The bench SHALL cover: green ph0 with req=0010 (req[0] low) -> green exactly 4 cycles, served pulse once.
REQ-036 The bench SHALL cover: req=1111 from IDLE held -> phase order 1,2,3,0,1 with each green 10 cycles.
REQ-037 The bench SHALL cover: preempt=1, preempt_ph=3 at green ph0 timer 1 -> yellow next cycle, 3 yel, 2 red, grn=1000 held while preempt is high.
REQ-038 The bench SHALL cover: rst_n pulsed low mid-YELLOW -> outputs revert to REQ-030 values asynchronously, before the next clock edge.
